md_arb: RTL

- Two-requester arbiter that shares the single multiply/divide unit between issue slot 0 and issue slot 1 of a dual-issue front end.
- Selects one request per cycle with round-robin priority and holds it in a one-entry output buffer feeding the md unit.
- Records which slot owns the in-flight operation so writeback can steer the result back to that slot.
- Handles pipeline abort for both the buffered and the in-flight operation.

---
 rtl/md_arb.sv | 134 +++++++++++++
 1 files changed

// File: rtl/md_arb.sv
// Round-robin arbiter sharing one multiply/divide unit between two issue slots,
// with a one-entry request buffer and tracking of the slot owning the in-flight op.
module md_arb #(
    parameter int unsigned XLEN  = 64,
    parameter int unsigned DST_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [XLEN-1:0]  r0_pc,
    input  logic [DST_W-1:0] r0_dst,
    input  logic [XLEN-1:0]  r0_operand1,
    input  logic [XLEN-1:0]  r0_operand2,
    input  logic [2:0]       r0_md_op,
    input  logic             r0_muldiv,
    input  logic             r0_valid,
    output logic             r0_ready,
    input  logic [XLEN-1:0]  r1_pc,
    input  logic [DST_W-1:0] r1_dst,
    input  logic [XLEN-1:0]  r1_operand1,
    input  logic [XLEN-1:0]  r1_operand2,
    input  logic [2:0]       r1_md_op,
    input  logic             r1_muldiv,
    input  logic             r1_valid,
    output logic             r1_ready,
    output logic [XLEN-1:0]  ix_md_pc,
    output logic [DST_W-1:0] ix_md_dst,
    output logic [XLEN-1:0]  ix_md_operand1,
    output logic [XLEN-1:0]  ix_md_operand2,
    output logic [2:0]       ix_md_md_op,
    output logic             ix_md_muldiv,
    output logic             ix_md_valid,
    input  logic             ix_md_ready,
    input  logic             md_wb_valid,
    input  logic             md_wb_ready,
    output logic             wb_owner,
    output logic             wb_owner_valid,
    input  logic             md_abort
);

    typedef struct packed {
        logic [XLEN-1:0]  pc;
        logic [DST_W-1:0] dst;
        logic [XLEN-1:0]  operand1;
        logic [XLEN-1:0]  operand2;
        logic [2:0]       md_op;
        logic             muldiv;
        logic             owner;
    } entry_t;

    entry_t buf_q, buf_d;
    logic   buf_valid_q, buf_valid_d;
    logic   rr_ptr_q, rr_ptr_d;
    logic   inflight_q, inflight_d;
    logic   owner_q, owner_d;

    logic   buf_free;
    logic   md_hs;
    logic   grant;
    logic   winner;

    always_comb begin
        buf_free = !buf_valid_q || ix_md_ready;
        // An aborted handshake is not a real issue to md, so it must not touch in-flight state.
        md_hs    = buf_valid_q && ix_md_ready && !md_abort;
        winner   = (r0_valid && r1_valid) ? rr_ptr_q : r1_valid;
        grant    = buf_free && !md_abort && !rst && (r0_valid || r1_valid);
        r0_ready = grant && !winner;
        r1_ready = grant && winner;
    end

    always_comb begin
        buf_d       = buf_q;
        buf_valid_d = buf_valid_q;
        rr_ptr_d    = rr_ptr_q;
        if (md_abort) begin
            buf_valid_d = 1'b0;
        end else if (grant) begin
            buf_valid_d = 1'b1;
            rr_ptr_d    = ~winner;
            if (winner) begin
                buf_d = '{pc: r1_pc, dst: r1_dst, operand1: r1_operand1,
                          operand2: r1_operand2, md_op: r1_md_op,
                          muldiv: r1_muldiv, owner: 1'b1};
            end else begin
                buf_d = '{pc: r0_pc, dst: r0_dst, operand1: r0_operand1,
                          operand2: r0_operand2, md_op: r0_md_op,
                          muldiv: r0_muldiv, owner: 1'b0};
            end
        end else if (md_hs) begin
            buf_valid_d = 1'b0;
        end
    end

    always_comb begin
        inflight_d = inflight_q;
        owner_d    = owner_q;
        // md suppresses writeback on abort; an idle, ready md with nothing buffered means nothing is in flight.
        if (md_hs) begin
            inflight_d = 1'b1;
            owner_d    = buf_q.owner;
        end else if (md_wb_valid && md_wb_ready) begin
            inflight_d = 1'b0;
        end else if (ix_md_ready && !buf_valid_q) begin
            inflight_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            buf_q       <= '0;
            buf_valid_q <= 1'b0;
            rr_ptr_q    <= 1'b0;
            inflight_q  <= 1'b0;
            owner_q     <= 1'b0;
        end else begin
            buf_q       <= buf_d;
            buf_valid_q <= buf_valid_d;
            rr_ptr_q    <= rr_ptr_d;
            inflight_q  <= inflight_d;
            owner_q     <= owner_d;
        end
    end

    assign ix_md_pc       = buf_q.pc;
    assign ix_md_dst      = buf_q.dst;
    assign ix_md_operand1 = buf_q.operand1;
    assign ix_md_operand2 = buf_q.operand2;
    assign ix_md_md_op    = buf_q.md_op;
    assign ix_md_muldiv   = buf_q.muldiv;
    assign ix_md_valid    = buf_valid_q;
    assign wb_owner       = owner_q;
    assign wb_owner_valid = inflight_q;

endmodule
